// File: rtl/video_blit_engine.sv
// ---------------------------------------------------------------------------
// video_blit_engine
//
// Rectangle fill/copy engine that sits on the video memory port. Software
// programs source, destination, size, stride and fill value through a small
// word-addressed register file, then sets CTRL.start. The engine walks the
// rectangle row-major and issues one word access per granted request on a
// request/grant master port that an external arbiter shares with the CPU.
//
// Ports:
//   rst        async active-high reset
//   clk_a      clock (same as the video memory port clock)
//   cfg_en     register access strobe
//   cfg_we     register write (full 32-bit)
//   cfg_addr   register word index (0..7)
//   cfg_wdata  register write data
//   cfg_rdata  registered read data, valid one cycle after cfg_en
//   vm_req     engine wants the memory port this cycle
//   vm_gnt     arbiter grant, combinational in the same cycle
//   vm_en      access strobe (vm_req & vm_gnt)
//   vm_we      4'hF on writes, 0 on reads
//   vm_addr    {1'b0, word address}
//   vm_write   write data
//   vm_read    read data, valid one cycle after a granted read
//   irq        level interrupt = done & irq_en
// ---------------------------------------------------------------------------
module video_blit_engine #(
    parameter int ADDR_WIDTH = 15,
    parameter int DIM_WIDTH  = 8
) (
    input  logic        rst,
    input  logic        clk_a,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [2:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    output logic        vm_req,
    input  logic        vm_gnt,
    output logic        vm_en,
    output logic [3:0]  vm_we,
    output logic [15:0] vm_addr,
    output logic [31:0] vm_write,
    input  logic [31:0] vm_read,
    output logic        irq
);

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DIM_WIDTH-1:0]  dim_t;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        RD,
        CAP,
        WR,
        DONE
    } state_t;

    localparam logic [2:0] REG_SRC    = 3'd0;
    localparam logic [2:0] REG_DST    = 3'd1;
    localparam logic [2:0] REG_SIZE   = 3'd2;
    localparam logic [2:0] REG_STRIDE = 3'd3;
    localparam logic [2:0] REG_FILL   = 3'd4;
    localparam logic [2:0] REG_CTRL   = 3'd5;
    localparam logic [2:0] REG_STATUS = 3'd6;

    // Software-visible programming registers
    addr_t       src_q, dst_q, stride_q;
    dim_t        width_q, height_q;
    logic [31:0] fill_q;
    logic        mode_q, irq_en_q, done_q, aborted_q;

    // Operation state: operands are latched at start so register writes
    // during an operation only affect the next one.
    state_t      state_q, state_d;
    addr_t       src_row_q, dst_row_q, op_stride_q;
    dim_t        op_width_q, op_height_q, col_q, row_q;
    logic [31:0] op_fill_q, hold_q;
    logic        abort_pend_q;

    logic        cfg_wr, ctrl_wr, status_wr;
    logic        start_cmd, abort_cmd, busy, abort_now;
    logic        zero_dims, last_col, last_row;
    logic        load, advance, capture, abort_exit;
    addr_t       rd_addr, wr_addr;
    logic [31:0] rdata_d;

    assign cfg_wr    = cfg_en & cfg_we;
    assign ctrl_wr   = cfg_wr && (cfg_addr == REG_CTRL);
    assign status_wr = cfg_wr && (cfg_addr == REG_STATUS);
    assign start_cmd = ctrl_wr & cfg_wdata[0];
    assign abort_cmd = ctrl_wr & cfg_wdata[2];

    assign busy = (state_q == FILL) || (state_q == RD) ||
                  (state_q == CAP)  || (state_q == WR);

    // An abort is remembered until the in-flight word has finished, so a
    // read already granted still gets its write before the engine stops.
    assign abort_now = busy & (abort_cmd | abort_pend_q);

    assign zero_dims = (width_q == '0) || (height_q == '0);
    assign last_col  = (col_q == op_width_q - dim_t'(1));
    assign last_row  = (row_q == op_height_q - dim_t'(1));

    // Row base plus column; the sum truncates, giving modulo-2^ADDR_WIDTH wrap.
    assign rd_addr = src_row_q + addr_t'(col_q);
    assign wr_addr = dst_row_q + addr_t'(col_q);

    // ------------------------------------------------------------------
    // FSM next-state and master-port outputs
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_d    = state_q;
        load       = 1'b0;
        advance    = 1'b0;
        capture    = 1'b0;
        abort_exit = 1'b0;
        vm_req     = 1'b0;
        vm_we      = 4'h0;
        vm_addr    = 16'h0;
        vm_write   = 32'h0;

        case (state_q)
            IDLE: begin
                if (start_cmd) begin
                    if (zero_dims) begin
                        state_d = DONE;
                    end else begin
                        load    = 1'b1;
                        state_d = cfg_wdata[1] ? RD : FILL;
                    end
                end
            end
            FILL: begin
                vm_req   = 1'b1;
                vm_we    = 4'hF;
                vm_addr  = 16'(wr_addr);
                vm_write = op_fill_q;
                if (vm_gnt) begin
                    advance = 1'b1;
                    if (abort_now) begin
                        state_d    = IDLE;
                        abort_exit = 1'b1;
                    end else if (last_col && last_row) begin
                        state_d = DONE;
                    end
                end else if (abort_now) begin
                    state_d    = IDLE;
                    abort_exit = 1'b1;
                end
            end
            RD: begin
                vm_req  = 1'b1;
                vm_addr = 16'(rd_addr);
                if (vm_gnt) begin
                    state_d = CAP;
                end else if (abort_now) begin
                    state_d    = IDLE;
                    abort_exit = 1'b1;
                end
            end
            CAP: begin
                capture = 1'b1;
                state_d = WR;
            end
            WR: begin
                // A captured word is always written, even with abort pending.
                vm_req   = 1'b1;
                vm_we    = 4'hF;
                vm_addr  = 16'(wr_addr);
                vm_write = hold_q;
                if (vm_gnt) begin
                    advance = 1'b1;
                    if (abort_now) begin
                        state_d    = IDLE;
                        abort_exit = 1'b1;
                    end else if (last_col && last_row) begin
                        state_d = DONE;
                    end else begin
                        state_d = RD;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign vm_en = vm_req & vm_gnt;
    assign irq   = done_q & irq_en_q;

    // ------------------------------------------------------------------
    // State register and operation datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk_a or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // flop samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= IDLE;
            src_row_q    <= '0;
            dst_row_q    <= '0;
            op_stride_q  <= '0;
            op_width_q   <= '0;
            op_height_q  <= '0;
            op_fill_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            abort_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_pend_q <= abort_now && (state_d != IDLE);
            if (load) begin
                src_row_q   <= src_q;
                dst_row_q   <= dst_q;
                op_stride_q <= stride_q;
                op_width_q  <= width_q;
                op_height_q <= height_q;
                op_fill_q   <= fill_q;
                col_q       <= '0;
                row_q       <= '0;
            end else if (advance) begin
                if (last_col) begin
                    col_q     <= '0;
                    row_q     <= row_q + dim_t'(1);
                    src_row_q <= src_row_q + op_stride_q;
                    dst_row_q <= dst_row_q + op_stride_q;
                end else begin
                    col_q <= col_q + dim_t'(1);
                end
            end
            if (capture) begin
                hold_q <= vm_read;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file writes and sticky status bits
    // ------------------------------------------------------------------
    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            src_q     <= '0;
            dst_q     <= '0;
            stride_q  <= '0;
            width_q   <= '0;
            height_q  <= '0;
            fill_q    <= '0;
            mode_q    <= 1'b0;
            irq_en_q  <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            if (cfg_wr) begin
                case (cfg_addr)
                    REG_SRC:    src_q    <= cfg_wdata[ADDR_WIDTH-1:0];
                    REG_DST:    dst_q    <= cfg_wdata[ADDR_WIDTH-1:0];
                    REG_SIZE: begin
                        width_q  <= cfg_wdata[DIM_WIDTH-1:0];
                        height_q <= cfg_wdata[2*DIM_WIDTH-1:DIM_WIDTH];
                    end
                    REG_STRIDE: stride_q <= cfg_wdata[ADDR_WIDTH-1:0];
                    REG_FILL:   fill_q   <= cfg_wdata;
                    REG_CTRL: begin
                        mode_q   <= cfg_wdata[1];
                        irq_en_q <= cfg_wdata[3];
                    end
                    default: ;
                endcase
            end
            // Set beats a same-cycle write-1-to-clear.
            done_q    <= (state_q == DONE) | (done_q & ~(status_wr & cfg_wdata[1]));
            aborted_q <= abort_exit | (aborted_q & ~(status_wr & cfg_wdata[2]));
        end
    end

    // ------------------------------------------------------------------
    // Registered read port
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = 32'h0;
        case (cfg_addr)
            REG_SRC:    rdata_d = 32'(src_q);
            REG_DST:    rdata_d = 32'(dst_q);
            REG_SIZE:   rdata_d = 32'({height_q, width_q});
            REG_STRIDE: rdata_d = 32'(stride_q);
            REG_FILL:   rdata_d = fill_q;
            REG_CTRL:   rdata_d = {28'h0, irq_en_q, 1'b0, mode_q, 1'b0};
            REG_STATUS: rdata_d = {29'h0, aborted_q, done_q, busy};
            default:    rdata_d = 32'h0;
        endcase
    end

    always_ff @(posedge clk_a or posedge rst) begin
        if (rst) begin
            cfg_rdata <= 32'h0;
        end else if (cfg_en && !cfg_we) begin
            cfg_rdata <= rdata_d;
        end
    end

endmodule

// File: tb/tb_video_blit_engine.sv
// ---------------------------------------------------------------------------
// tb_video_blit_engine
//
// Self-checking bench for video_blit_engine. A behavioural model predicts the
// full ordered list of memory accesses for each operation from the register
// values (row-major walk, modulo-2^15 addresses, sequential copy semantics on
// a shadow memory). A monitor compares every granted access against that list
// and checks that outputs hold while a request is not granted. A word memory
// answers reads one cycle after grant. Directed cases pin the model with
// literal addresses, data and timings.
// ---------------------------------------------------------------------------
module tb_video_blit_engine;

    logic        rst;
    logic        clk_a;
    logic        cfg_en;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        vm_req;
    logic        vm_gnt;
    logic        vm_en;
    logic [3:0]  vm_we;
    logic [15:0] vm_addr;
    logic [31:0] vm_write;
    logic [31:0] vm_read;
    logic        irq;

    video_blit_engine dut (
        .rst       (rst),
        .clk_a     (clk_a),
        .cfg_en    (cfg_en),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_rdata (cfg_rdata),
        .vm_req    (vm_req),
        .vm_gnt    (vm_gnt),
        .vm_en     (vm_en),
        .vm_we     (vm_we),
        .vm_addr   (vm_addr),
        .vm_write  (vm_write),
        .vm_read   (vm_read),
        .irq       (irq)
    );

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;
    } acc_t;

    typedef struct {
        bit          we;
        logic [15:0] addr;
        logic [31:0] data;
        int          cyc;
    } log_t;

    acc_t        exp_q[$];
    log_t        log_q[$];
    logic [31:0] mem       [0:32767];
    logic [31:0] model_mem [0:32767];

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_writes = 0;
    int   n_acc    = 0;
    int   gnt_mode = 0;   // 0: always granted, 1: random, 2: pattern 1,0,0,1
    bit   rd_pend  = 1'b0;
    logic [14:0] rd_addr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // Clock
    initial begin
        clk_a = 1'b0;
        forever #5 clk_a = ~clk_a;
    end

    // Watchdog
    initial begin
        #900_000;
        $display("FAIL watchdog: actual simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    // Arbiter grant and memory read data, driven just after each rising edge
    initial begin
        bit pat [4];
        int pidx;
        pat  = '{1'b1, 1'b0, 1'b0, 1'b1};
        pidx = 0;
        vm_gnt  = 1'b0;
        vm_read = 32'h0;
        forever begin
            @(posedge clk_a);
            #1;
            case (gnt_mode)
                0:       vm_gnt = 1'b1;
                1:       vm_gnt = 1'($urandom_range(0, 1));
                default: begin
                    vm_gnt = pat[pidx];
                    pidx   = (pidx + 1) % 4;
                end
            endcase
            if (rd_pend) vm_read = mem[rd_addr];
            else         vm_read = $urandom;
        end
    end

    // Monitor: compares every granted access with the model's list
    initial begin
        int          cyc;
        bit          prev_req, prev_gnt;
        logic [15:0] prev_addr;
        logic [3:0]  prev_we;
        logic [31:0] prev_write;
        acc_t        e;
        log_t        l;
        cyc = 0;
        prev_req = 1'b0;
        prev_gnt = 1'b0;
        prev_addr = '0;
        prev_we = '0;
        prev_write = '0;
        forever begin
            @(negedge clk_a);
            if (rst) begin
                prev_req = 1'b0;
                rd_pend  = 1'b0;
            end else begin
                cyc++;
                check("vm_en_eq_req_and_gnt", 32'(vm_en), 32'(vm_req & vm_gnt));
                if (vm_req) check("vm_addr_msb_zero", 32'(vm_addr[15]), 32'h0);
                if (prev_req && !prev_gnt && vm_req) begin
                    check("hold_addr",  32'(vm_addr), 32'(prev_addr));
                    check("hold_we",    32'(vm_we),   32'(prev_we));
                    check("hold_write", vm_write,     prev_write);
                end
                rd_pend = 1'b0;
                if (vm_en) begin
                    n_acc++;
                    l.we = (vm_we != 4'h0);
                    l.addr = vm_addr;
                    l.data = vm_write;
                    l.cyc = cyc;
                    log_q.push_back(l);
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_access",
                                 $sformatf("actual access addr=0x%04h we=0x%0h, required none", vm_addr, vm_we));
                    end else begin
                        e = exp_q.pop_front();
                        check("acc_we",   32'(vm_we),   e.we ? 32'hF : 32'h0);
                        check("acc_addr", 32'(vm_addr), 32'(e.addr));
                        if (e.we) check("acc_data", vm_write, e.data);
                    end
                    if (vm_we == 4'h0) begin
                        rd_pend = 1'b1;
                        rd_addr = vm_addr[14:0];
                    end else begin
                        mem[vm_addr[14:0]] = vm_write;
                        n_writes++;
                    end
                end
                prev_req   = vm_req;
                prev_gnt   = vm_gnt;
                prev_addr  = vm_addr;
                prev_we    = vm_we;
                prev_write = vm_write;
            end
        end
    end

    // ------------------------------------------------------------------
    // Behavioural model and stimulus helpers
    // ------------------------------------------------------------------
    task automatic init_mem();
        logic [31:0] v;
        for (int i = 0; i < 32768; i++) begin
            v = $urandom;
            mem[i] = v;
            model_mem[i] = v;
        end
    endtask

    // Word (r, c) lives at base + r*stride + c, modulo 2^15. Copy reads the
    // shadow memory as already modified by earlier words of the same copy.
    task automatic predict(input bit copy, input logic [14:0] src, input logic [14:0] dst,
                           input logic [14:0] stride, input logic [7:0] w, input logic [7:0] h,
                           input logic [31:0] fill);
        acc_t        e;
        int          sa_i, da_i;
        logic [14:0] sa, da;
        logic [31:0] d;
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
                sa_i = int'(src) + r * int'(stride) + c;
                da_i = int'(dst) + r * int'(stride) + c;
                sa = sa_i[14:0];
                da = da_i[14:0];
                if (copy) begin
                    e.we = 1'b0; e.addr = {1'b0, sa}; e.data = 32'h0;
                    exp_q.push_back(e);
                    d = model_mem[sa];
                end else begin
                    d = fill;
                end
                e.we = 1'b1; e.addr = {1'b0, da}; e.data = d;
                exp_q.push_back(e);
                model_mem[da] = d;
            end
        end
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [31:0] d);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk_a);
        #1;
        cfg_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfg_rd(input logic [2:0] a, output logic [31:0] d);
        cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = a;
        @(posedge clk_a);
        #1;
        cfg_en = 1'b0;
        d = cfg_rdata;
    endtask

    task automatic setup(input bit copy, input logic [31:0] src_w, input logic [31:0] dst_w,
                         input logic [31:0] stride_w, input logic [7:0] w, input logic [7:0] h,
                         input logic [31:0] fill, input bit ien);
        cfg_wr(3'd0, src_w);
        cfg_wr(3'd1, dst_w);
        cfg_wr(3'd2, {16'h0, h, w});
        cfg_wr(3'd3, stride_w);
        cfg_wr(3'd4, fill);
        cfg_wr(3'd6, 32'h6);
        predict(copy, src_w[14:0], dst_w[14:0], stride_w[14:0], w, h, fill);
        cfg_wr(3'd5, {28'h0, ien, 1'b0, copy, 1'b1});
    endtask

    task automatic wait_done(output logic [31:0] st);
        st = 32'h1;
        for (int i = 0; i < 3000; i++) begin
            cfg_rd(3'd6, st);
            if (!st[0] && (st[1] || st[2])) return;
        end
        fail_now("op_timeout", "actual engine still busy, required done or aborted within 3000 polls");
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        logic [31:0] st, rd, src_w, dst_w, stride_w, fill_w;
        logic [7:0]  w, h;
        bit          copy;
        int          li, nw0, na0;

        rst = 1'b1;
        cfg_en = 1'b0; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_wdata = 32'h0;
        init_mem();
        repeat (3) @(posedge clk_a);
        #1;
        check("reset_vm_req",    32'(vm_req),   32'h0);
        check("reset_vm_we",     32'(vm_we),    32'h0);
        check("reset_vm_addr",   32'(vm_addr),  32'h0);
        check("reset_vm_write",  vm_write,      32'h0);
        check("reset_cfg_rdata", cfg_rdata,     32'h0);
        check("reset_irq",       32'(irq),      32'h0);
        rst = 1'b0;
        @(posedge clk_a);
        #1;

        // Fill 4x2 at 0x0100, stride 0x80, always granted
        gnt_mode = 0;
        li = log_q.size();
        setup(1'b0, 32'h0, 32'h0100, 32'h80, 8'd4, 8'd2, 32'hDEADBEEF, 1'b0);
        wait_done(st);
        check("fill_status", st & 32'h7, 32'h2);
        check("fill_count", 32'(log_q.size() - li), 32'd8);
        if (log_q.size() >= li + 8) begin
            check("fill_first_addr", 32'(log_q[li].addr),     32'h0100);
            check("fill_row0_end",   32'(log_q[li+3].addr),   32'h0103);
            check("fill_row1_start", 32'(log_q[li+4].addr),   32'h0180);
            check("fill_last_addr",  32'(log_q[li+7].addr),   32'h0183);
            check("fill_data",       log_q[li+5].data,        32'hDEADBEEF);
            check("fill_back_to_back", 32'(log_q[li+7].cyc - log_q[li].cyc), 32'd7);
        end
        check("fill_drained", 32'(exp_q.size()), 32'h0);

        // Copy 3x1 from 0x0000 to 0x1000
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33;
        model_mem[0] = 32'h11; model_mem[1] = 32'h22; model_mem[2] = 32'h33;
        li = log_q.size();
        setup(1'b1, 32'h0, 32'h1000, 32'h0, 8'd3, 8'd1, 32'h0, 1'b0);
        wait_done(st);
        check("copy_status", st & 32'h7, 32'h2);
        check("copy_count", 32'(log_q.size() - li), 32'd6);
        if (log_q.size() >= li + 6) begin
            check("copy_w0", log_q[li+1].data, 32'h11);
            check("copy_w1", log_q[li+3].data, 32'h22);
            check("copy_w2", log_q[li+5].data, 32'h33);
            check("copy_w2_addr", 32'(log_q[li+5].addr), 32'h1002);
            check("copy_rd_to_wr", 32'(log_q[li+1].cyc - log_q[li].cyc), 32'd2);
            check("copy_word_period", 32'(log_q[li+2].cyc - log_q[li].cyc), 32'd3);
        end
        check("copy_drained", 32'(exp_q.size()), 32'h0);

        // Fill 2x1 across the address wrap
        li = log_q.size();
        setup(1'b0, 32'h0, 32'h7FFF, 32'h0, 8'd2, 8'd1, 32'hA5A5_0001, 1'b0);
        wait_done(st);
        check("wrap_count", 32'(log_q.size() - li), 32'd2);
        if (log_q.size() >= li + 2) begin
            check("wrap_addr0", 32'(log_q[li].addr),   32'h7FFF);
            check("wrap_addr1", 32'(log_q[li+1].addr), 32'h0000);
        end

        // Fill 3x2 with grant pattern 1,0,0,1
        gnt_mode = 2;
        nw0 = n_writes;
        setup(1'b0, 32'h0, 32'h2000, 32'h10, 8'd3, 8'd2, 32'h1234_5678, 1'b0);
        wait_done(st);
        check("toggle_write_count", 32'(n_writes - nw0), 32'd6);
        check("toggle_drained", 32'(exp_q.size()), 32'h0);
        gnt_mode = 0;

        // WIDTH=0 with irq enabled
        na0 = n_acc;
        setup(1'b0, 32'h0, 32'h0300, 32'h0, 8'd0, 8'd3, 32'h0, 1'b1);
        repeat (2) @(posedge clk_a);
        #1;
        check("zero_dim_irq", 32'(irq), 32'h1);
        check("zero_dim_no_access", 32'(n_acc - na0), 32'h0);
        cfg_wr(3'd6, 32'h2);
        check("irq_cleared", 32'(irq), 32'h0);
        cfg_rd(3'd5, rd);
        check("ctrl_readback", rd, 32'h8);
        cfg_wr(3'd5, 32'h0);

        // Randomized fills and copies with random grant
        gnt_mode = 1;
        for (int it = 0; it < 30; it++) begin
            copy     = 1'($urandom_range(0, 1));
            w        = 8'($urandom_range(0, 6));
            h        = 8'($urandom_range(1, 4));
            src_w    = $urandom;
            dst_w    = (it % 3 == 0) ? src_w + 32'($urandom_range(0, 6)) - 32'd3 : $urandom;
            stride_w = (it % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            fill_w   = $urandom;
            nw0      = n_writes;
            setup(copy, src_w, dst_w, stride_w, w, h, fill_w, 1'b0);
            cfg_wr(3'd0, $urandom);
            cfg_wr(3'd4, $urandom);
            cfg_wr(3'd2, $urandom);
            wait_done(st);
            check("rand_status", st & 32'h7, 32'h2);
            check("rand_write_count", 32'(n_writes - nw0), 32'(int'(w) * int'(h)));
            check("rand_drained", 32'(exp_q.size()), 32'h0);
        end

        // Abort a 16-word fill after a few writes
        gnt_mode = 0;
        nw0 = n_writes;
        setup(1'b0, 32'h0, 32'h3000, 32'h0, 8'd16, 8'd1, 32'hCAFE_F00D, 1'b0);
        repeat (4) @(posedge clk_a);
        #1;
        cfg_wr(3'd5, 32'h4);
        wait_done(st);
        check("abort_status", st & 32'h7, 32'h4);
        check("abort_write_bound", 32'((n_writes - nw0) <= 6 && (n_writes - nw0) >= 1), 32'h1);
        nw0 = n_writes;
        exp_q.delete();
        repeat (5) @(posedge clk_a);
        #1;
        check("abort_quiet", 32'(n_writes - nw0), 32'h0);
        init_mem();

        // Reset in the middle of a copy
        setup(1'b1, 32'h5000, 32'h6000, 32'h20, 8'd8, 8'd4, 32'h0, 1'b1);
        repeat (6) @(posedge clk_a);
        #3;
        rst = 1'b1;
        #1;
        check("rst_vm_req_async", 32'(vm_req), 32'h0);
        check("rst_vm_en_async",  32'(vm_en),  32'h0);
        exp_q.delete();
        repeat (3) @(posedge clk_a);
        #1;
        check("rst_hold_vm_req", 32'(vm_req), 32'h0);
        check("rst_cfg_rdata",   cfg_rdata,    32'h0);
        rst = 1'b0;
        na0 = n_acc;
        for (int r = 0; r < 8; r++) begin
            cfg_rd(3'(r), rd);
            check($sformatf("rst_reg%0d", r), rd, 32'h0);
        end
        check("rst_no_access", 32'(n_acc - na0), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
